// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock divider. Each channel divides I_REF_CLK by its
// active ratio and swaps in a newly loaded ratio only at a period boundary, bypass edge or sync.

module clk_div_ch #(
    parameter int RATIO_W   = 8,
    parameter int DEF_RATIO = 1
) (
    input  logic               I_REF_CLK,
    input  logic               RST_EN,
    input  logic               clk_en,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               ratio_ld,
    input  logic               sync_req,
    output logic               div_clk,
    output logic               tick,
    output logic               ratio_ack
);
    localparam logic [RATIO_W-1:0] DEF_R = RATIO_W'(DEF_RATIO);

    logic [RATIO_W-1:0] r_q, p_q, cnt_q, cnt_nxt, r_m1, half, new_r;
    logic               pf_q, out_q, div_mode, wrap, apply;

    assign div_mode = clk_en && (r_q >= RATIO_W'(2));
    // R-1 is only meaningful for R>=2; clamp so 0/1 never wrap around
    assign r_m1     = (r_q >= RATIO_W'(2)) ? r_q - RATIO_W'(1) : '0;
    // one extra bit so the largest ratio does not overflow before the shift
    assign half     = RATIO_W'(({1'b0, r_q} + {{RATIO_W{1'b0}}, 1'b1}) >> 1);
    assign wrap     = div_mode && (cnt_q == r_m1);
    assign cnt_nxt  = wrap ? '0 : cnt_q + RATIO_W'(1);
    assign new_r    = ratio_ld ? ratio : p_q;
    assign apply    = (pf_q || ratio_ld) && (sync_req || !div_mode || wrap);

    always_ff @(posedge I_REF_CLK or negedge RST_EN) begin
        if (!RST_EN) begin
            r_q       <= DEF_R;
            p_q       <= DEF_R;
            pf_q      <= 1'b0;
            cnt_q     <= '0;
            out_q     <= 1'b1;
            tick      <= 1'b0;
            ratio_ack <= 1'b0;
        end else begin
            tick      <= 1'b0;
            ratio_ack <= 1'b0;
            if (apply) begin
                r_q       <= new_r;
                p_q       <= new_r;
                pf_q      <= 1'b0;
                cnt_q     <= '0;
                out_q     <= 1'b1;
                ratio_ack <= 1'b1;
                tick      <= div_mode;
            end else begin
                if (ratio_ld) begin
                    p_q  <= ratio;
                    pf_q <= 1'b1;
                end
                // sync beats the natural wrap; bypass simply holds state
                if (sync_req) begin
                    cnt_q <= '0;
                    out_q <= 1'b1;
                    tick  <= div_mode;
                end else if (div_mode) begin
                    cnt_q <= cnt_nxt;
                    out_q <= (cnt_nxt < half);
                    tick  <= (cnt_nxt == '0);
                end
            end
        end
    end

    assign div_clk = div_mode ? out_q : I_REF_CLK;
endmodule

module clk_div_mc #(
    parameter int NUM_CH    = 2,
    parameter int RATIO_W   = 8,
    parameter int DEF_RATIO = 1
) (
    input  logic                      I_REF_CLK,
    input  logic                      RST_EN,
    input  logic [NUM_CH-1:0]         CLK_EN,
    input  logic [NUM_CH*RATIO_W-1:0] DIV_RATIO,
    input  logic [NUM_CH-1:0]         RATIO_LD,
    input  logic                      SYNC_REQ,
    output logic [NUM_CH-1:0]         O_DIV_CLK,
    output logic [NUM_CH-1:0]         O_TICK,
    output logic [NUM_CH-1:0]         O_RATIO_ACK
);
    logic [NUM_CH-1:0][RATIO_W-1:0] ratio_v;

    assign ratio_v = DIV_RATIO;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .RATIO_W   (RATIO_W),
            .DEF_RATIO (DEF_RATIO)
        ) u_ch (
            .I_REF_CLK (I_REF_CLK),
            .RST_EN    (RST_EN),
            .clk_en    (CLK_EN[i]),
            .ratio     (ratio_v[i]),
            .ratio_ld  (RATIO_LD[i]),
            .sync_req  (SYNC_REQ),
            .div_clk   (O_DIV_CLK[i]),
            .tick      (O_TICK[i]),
            .ratio_ack (O_RATIO_ACK[i])
        );
    end
endmodule

// File: tb/tb_clk_div_mc.sv
// Scoreboard bench for clk_div_mc: stimulus queues expected tick/ack events with their
// cycle and measured period/high time; a negedge monitor pops and compares them.

module tb_clk_div_mc;
    localparam int NUM_CH = 2;
    localparam int RW     = 8;
    localparam int K_ACK  = 0;
    localparam int K_TICK = 1;

    logic                 I_REF_CLK;
    logic                 RST_EN;
    logic [NUM_CH-1:0]    CLK_EN;
    logic [NUM_CH*RW-1:0] DIV_RATIO;
    logic [NUM_CH-1:0]    RATIO_LD;
    logic                 SYNC_REQ;
    logic [NUM_CH-1:0]    O_DIV_CLK;
    logic [NUM_CH-1:0]    O_TICK;
    logic [NUM_CH-1:0]    O_RATIO_ACK;

    clk_div_mc #(.NUM_CH(NUM_CH), .RATIO_W(RW), .DEF_RATIO(1)) dut (
        .I_REF_CLK   (I_REF_CLK),
        .RST_EN      (RST_EN),
        .CLK_EN      (CLK_EN),
        .DIV_RATIO   (DIV_RATIO),
        .RATIO_LD    (RATIO_LD),
        .SYNC_REQ    (SYNC_REQ),
        .O_DIV_CLK   (O_DIV_CLK),
        .O_TICK      (O_TICK),
        .O_RATIO_ACK (O_RATIO_ACK)
    );

    initial I_REF_CLK = 1'b0;
    always #5 I_REF_CLK = ~I_REF_CLK;

    int cyc = 0;
    always @(posedge I_REF_CLK) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int kind;
        int cyc;
        int len;
        int hi;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mlen[NUM_CH];
    int   mhi[NUM_CH];

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(int ch, int kind, int c, int len = -1, int hi = -1);
        exp_t e;
        e.ch = ch; e.kind = kind; e.cyc = c; e.len = len; e.hi = hi;
        sb.push_back(e);
    endtask

    // len/hi describe the samples since the previous event on this channel
    task automatic pop_chk(int ch, int kind, int rl, int rh);
        int   idx;
        exp_t e;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (sb[i].ch == ch) begin
                idx = i;
                break;
            end
        if (idx < 0) begin
            checks++;
            failures++;
            $display("FAIL ch%0d_unexpected_%s: event seen at cyc %0d, none required",
                     ch, (kind == K_ACK) ? "ack" : "tick", cyc);
        end else begin
            e = sb[idx];
            sb.delete(idx);
            chk($sformatf("ch%0d_kind", ch), kind, e.kind);
            chk($sformatf("ch%0d_%s_cyc", ch, (kind == K_ACK) ? "ack" : "tick"), cyc, e.cyc);
            if (e.len >= 0) begin
                chk($sformatf("ch%0d_period", ch), rl, e.len);
                chk($sformatf("ch%0d_high", ch), rh, e.hi);
            end
        end
    endtask

    initial begin
        int rl, rh;
        forever begin
            @(negedge I_REF_CLK);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                rl = mlen[ch];
                rh = mhi[ch];
                if (O_RATIO_ACK[ch]) pop_chk(ch, K_ACK, rl, rh);
                if (O_TICK[ch])      pop_chk(ch, K_TICK, rl, rh);
                if (O_RATIO_ACK[ch] || O_TICK[ch]) begin
                    mlen[ch] = 1;
                    mhi[ch]  = int'(O_DIV_CLK[ch]);
                end else begin
                    mlen[ch] = mlen[ch] + 1;
                    mhi[ch]  = mhi[ch] + int'(O_DIV_CLK[ch]);
                end
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge I_REF_CLK);
            #1;
        end
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) step();
    endtask

    task automatic load(int ch, int r);
        RATIO_LD[ch]          = 1'b1;
        DIV_RATIO[ch*RW +: RW] = RW'(r);
        step();
        RATIO_LD[ch]          = 1'b0;
    endtask

    // bypass: output follows the reference clock through both phases
    task automatic chk_byp(int ch, string nm);
        chk($sformatf("%s_hi", nm), int'(O_DIV_CLK[ch]), 1);
        @(negedge I_REF_CLK);
        #1;
        chk($sformatf("%s_lo", nm), int'(O_DIV_CLK[ch]), 0);
        step();
    endtask

    initial begin
        int c;
        RST_EN = 1'b0; CLK_EN = '0; DIV_RATIO = '0; RATIO_LD = '0; SYNC_REQ = 1'b0;
        step(2);
        chk("rst_tick", int'(O_TICK), 0);
        chk("rst_ack", int'(O_RATIO_ACK), 0);
        chk("rst_divclk_hi", int'(O_DIV_CLK), 3);
        @(negedge I_REF_CLK);
        #1;
        chk("rst_divclk_lo", int'(O_DIV_CLK), 0);
        step();
        RST_EN = 1'b1;
        step();
        chk_byp(0, "def_byp");

        // even ratio 4, applied through bypass
        c = cyc;
        push(0, K_ACK, c + 1);
        for (int k = 1; k <= 4; k++) push(0, K_TICK, c + 1 + 4 * k, 4, 2);
        CLK_EN[0] = 1'b1;
        load(0, 4);
        wait_cyc(c + 17);
        CLK_EN[0] = 1'b0;

        // odd ratio 5 over 20+ periods
        c = cyc;
        push(0, K_ACK, c + 1);
        for (int k = 0; k <= 20; k++) push(0, K_TICK, c + 6 + 5 * k, 5, 3);
        load(0, 5);
        CLK_EN[0] = 1'b1;
        wait_cyc(c + 106);
        CLK_EN[0] = 1'b0;

        // 6 -> 3 mid-period, double load: last wins, one ack at the boundary
        c = cyc;
        push(0, K_ACK, c + 1);
        push(0, K_ACK, c + 7);
        push(0, K_TICK, c + 7, 6, 3);
        for (int k = 1; k <= 3; k++) push(0, K_TICK, c + 7 + 3 * k, 3, 2);
        load(0, 6);
        CLK_EN[0] = 1'b1;
        wait_cyc(c + 3);
        load(0, 7);
        load(0, 3);
        wait_cyc(c + 16);
        CLK_EN[0] = 1'b0;

        // sync of ch0=4 and ch1=6 running out of phase
        c = cyc;
        push(0, K_ACK, c + 1);
        push(0, K_TICK, c + 5, 4, 2);
        push(0, K_TICK, c + 8, 3, 2);
        push(0, K_TICK, c + 12, 4, 2);
        push(1, K_ACK, c + 3);
        push(1, K_TICK, c + 8, 5, 3);
        push(1, K_TICK, c + 14, 6, 3);
        load(0, 4);
        CLK_EN[0] = 1'b1;
        step();
        CLK_EN[1] = 1'b1;
        load(1, 6);
        wait_cyc(c + 7);
        SYNC_REQ = 1'b1;
        step();
        SYNC_REQ = 1'b0;
        chk("sync_out_high", int'(O_DIV_CLK), 3);
        wait_cyc(c + 14);
        CLK_EN = '0;

        // ch0 paused at CNT=2 for 3 cycles, then resumes from there
        c = cyc + 3;
        push(0, K_TICK, c + 2);
        push(0, K_TICK, c + 6, 4, 2);
        wait_cyc(c);
        CLK_EN[0] = 1'b1;
        wait_cyc(c + 6);
        CLK_EN[0] = 1'b0;

        // ratios 0 and 1 bypass, 255 gives 128 high / 127 low
        c = cyc;
        push(0, K_ACK, c + 1);
        load(0, 0);
        CLK_EN[0] = 1'b1;
        chk_byp(0, "r0_byp");
        c = cyc;
        push(0, K_ACK, c + 1);
        load(0, 1);
        chk_byp(0, "r1_byp");
        c = cyc;
        push(0, K_ACK, c + 1);
        push(0, K_TICK, c + 256, 255, 128);
        load(0, 255);
        wait_cyc(c + 256);
        CLK_EN[0] = 1'b0;

        // reset with a pending ratio on ch1
        c = cyc;
        CLK_EN[1] = 1'b1;
        wait_cyc(c + 2);
        load(1, 3);
        #1;
        RST_EN = 1'b0;
        #1;
        chk("rst2_tick", int'(O_TICK), 0);
        chk("rst2_ack", int'(O_RATIO_ACK), 0);
        chk("rst2_divclk_hi", int'(O_DIV_CLK), 3);
        @(negedge I_REF_CLK);
        #1;
        chk("rst2_divclk_lo", int'(O_DIV_CLK), 0);
        step();
        RST_EN = 1'b1;
        for (int k = 0; k < 6; k++) chk_byp(1, "rst2_no_pend");

        // first divide after reset starts from CNT=0
        c = cyc;
        push(1, K_ACK, c + 1);
        push(1, K_TICK, c + 5, 4, 2);
        load(1, 4);
        wait_cyc(c + 5);
        CLK_EN = '0;
        step(4);
        chk("sb_leftover", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_mc.md
CLK_DIV_MC -- requirements
Module: clk_div_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent divider channels (1..8).
REQ-002 SHALL have parameter RATIO_W, default 8, width of each division ratio (2..16).
REQ-003 SHALL have parameter DEF_RATIO, default 1, active ratio of every channel after reset.
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- I_REF_CLK  in  1  reference clock; all state on its rising edge.
- RST_EN  in  1  asynchronous, active-low reset.
REQ-005 SHALL have the following data ports:
- CLK_EN  in  NUM_CH  per-channel divide enable.
- DIV_RATIO  in  NUM_CH*RATIO_W  per-channel ratio; channel i is bits [i*RATIO_W +: RATIO_W].
- RATIO_LD  in  NUM_CH  per-channel one-cycle load strobe for DIV_RATIO.
- SYNC_REQ  in  1  one-cycle strobe that phase-realigns all channels.
- O_DIV_CLK  out  NUM_CH  divided clocks.
- O_TICK  out  NUM_CH  one-cycle pulse marking each divided-clock rising edge.
- O_RATIO_ACK  out  NUM_CH  one-cycle pulse when a loaded ratio becomes active.

Function
REQ-006 Each channel SHALL hold the following registers:
- active ratio R.
- pending ratio P, with pending flag PF.
- counter CNT (RATIO_W bits).
- output register OUT.
REQ-007 A channel SHALL be in divide mode when CLK_EN[i]=1 and R>=2; otherwise it is in bypass.
REQ-008 In divide mode, on each edge:
- CNT <= (CNT==R-1) ? 0 : CNT+1.
- OUT <= (CNT_next < H), where H=(R+1)>>1.
- This gives a high phase of ceil(R/2) cycles and a low phase of floor(R/2) cycles; R=2 gives a 50% duty cycle.
REQ-009 O_TICK[i] SHALL be registered: 1 for exactly the cycle in which CNT_next==0 is loaded in divide mode, otherwise 0.
REQ-010 O_DIV_CLK[i] SHALL be OUT in divide mode and I_REF_CLK (combinational mux) in bypass.
REQ-011 In bypass, CNT and OUT SHALL hold their values.
REQ-012 RATIO_LD[i]=1 SHALL capture the channel's DIV_RATIO slice into P and set PF.
REQ-013 A second RATIO_LD while PF=1 SHALL overwrite P; the last load wins and only one ack is issued.
REQ-014 The pending ratio SHALL be applied (R<=P, PF<=0, CNT<=0, OUT<=1, O_RATIO_ACK[i] pulses 1 cycle) at the first of:
- a period boundary (CNT==R-1 in divide mode);
- any edge in bypass;
- SYNC_REQ.
REQ-015 A RATIO_LD coincident with an apply event SHALL have its DIV_RATIO applied in that same cycle, with the ack in the next cycle.
REQ-016 Ratio changes SHALL therefore never truncate a divided-clock high or low phase.
REQ-017 SYNC_REQ=1 SHALL force CNT<=0 and OUT<=1 in every channel simultaneously.
REQ-018 On SYNC_REQ, channels in divide mode SHALL pulse O_TICK in the next cycle.
REQ-019 SYNC_REQ SHALL take priority over period-boundary wrap.
REQ-020 A ratio of 0 or 1 (applied or at reset) SHALL select bypass; no arithmetic underflow is permitted on R-1.
REQ-021 Deasserting CLK_EN mid-period and reasserting it SHALL resume counting from the held CNT/OUT.
REQ-022 Channels SHALL be fully independent, except for shared SYNC_REQ and reset.

Reset
REQ-023 While RST_EN=0, each channel SHALL asynchronously reset to:
- R=DEF_RATIO, P=DEF_RATIO, PF=0.
- CNT=0, OUT=1.
- O_TICK=0, O_RATIO_ACK=0.
REQ-024 A reset asserted mid-operation SHALL discard pending ratios.
REQ-025 After RST_EN rises, the first divide-mode edge SHALL proceed from CNT=0.
REQ-026 With DEF_RATIO<2, O_DIV_CLK SHALL equal I_REF_CLK immediately after reset.

Verification
REQ-027 The bench SHALL cover:
- Even ratio: ch0 loads 4, CLK_EN=1 -> O_DIV_CLK period 4 cycles, 2 high/2 low; O_TICK once per 4 cycles; ack 1 cycle after the load (bypass apply).
- Odd ratio: load 5 -> period 5, 3 high/2 low, repeated over 20 periods.
- Mid-period change: running at 6, load 3 at CNT=2 -> the 6-period completes untouched; ack and first 3-period start at the boundary.
- SYNC_REQ: ch0=4 and ch1=6 with offset phases, SYNC_REQ pulse -> both OUT=1 and CNT=0 on the same edge, both ticks in the next cycle.
- Bypass/edge cases: load 0, then 1, then 255 (RATIO_W=8) -> bypass, bypass, period 255 with 128 high/127 low; CLK_EN low for 3 cycles -> counting resumes at the held CNT.
- Reset mid-operation: RST_EN low with PF=1 -> all outputs at reset values asynchronously; pending ratio is not applied after release.
